// File: rtl/sysid_boot_checker.sv
// Boot-time checker: reads sysid ID (addr 0) and timestamp (addr 1) over Avalon-MM and flags mismatches.
// Optional interrupt output enabled by defining SYSID_BOOT_CHECKER_IRQ_EN.
//
// state  | meaning
// IDLE   | waiting for start (or first clock after reset when AUTO_START)
// RD_ID  | read of address 0 outstanding, waiting for waitrequest low
// LAT_ID | read of address 0 accepted, waiting READ_LATENCY cycles for data
// RD_TS  | read of address 1 outstanding, waiting for waitrequest low
// LAT_TS | read of address 1 accepted, waiting READ_LATENCY cycles for data
// DONE   | results published; start re-runs the check
module sysid_boot_checker #(
  parameter logic [31:0] EXPECTED_ID        = 32'h0000_0000,
  parameter logic [31:0] EXPECTED_TIMESTAMP = 32'h5896_7A1C,
  parameter int          READ_LATENCY       = 0,
  parameter int          TIMEOUT_CYCLES     = 255,
  parameter bit          AUTO_START         = 1'b1
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  output logic        m_address,
  output logic        m_read,
  input  logic [31:0] m_readdata,
  input  logic        m_waitrequest,
  output logic        busy,
  output logic        done,
  output logic [31:0] id_value,
  output logic [31:0] ts_value,
  output logic        id_ok,
  output logic        ts_ok,
  output logic        timeout_err
`ifdef SYSID_BOOT_CHECKER_IRQ_EN
  ,
  output logic        irq,
  input  logic        irq_ack
`endif
);

  typedef enum logic [2:0] {IDLE, RD_ID, LAT_ID, RD_TS, LAT_TS, DONE} state_t;

  localparam int             TO_W     = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TO_W-1:0] TO_LOAD = (TIMEOUT_CYCLES > 0) ? TO_W'(TIMEOUT_CYCLES - 1) : '0;
  localparam bit             TO_EN    = (TIMEOUT_CYCLES != 0);
  localparam logic [2:0]     LAT_LOAD = (READ_LATENCY > 0) ? 3'(READ_LATENCY - 1) : 3'd0;
  localparam bit             LAT_EN   = (READ_LATENCY != 0);

  state_t            state_q, state_d;
  logic              started_q, started_d;
  logic [TO_W-1:0]   stall_q, stall_d;
  logic [2:0]        lat_q, lat_d;
  logic [31:0]       id_value_q, id_value_d;
  logic [31:0]       ts_value_q, ts_value_d;
  logic              id_got_q, id_got_d;
  logic              ts_got_q, ts_got_d;
  logic              done_q, done_d;
  logic              id_ok_q, id_ok_d;
  logic              ts_ok_q, ts_ok_d;
  logic              timeout_q, timeout_d;
  logic              capture;
`ifdef SYSID_BOOT_CHECKER_IRQ_EN
  logic              irq_q, irq_d;
`endif

  always_comb begin
    state_d    = state_q;
    started_d  = 1'b1;
    stall_d    = stall_q;
    lat_d      = lat_q;
    id_value_d = id_value_q;
    ts_value_d = ts_value_q;
    id_got_d   = id_got_q;
    ts_got_d   = ts_got_q;
    done_d     = done_q;
    id_ok_d    = id_ok_q;
    ts_ok_d    = ts_ok_q;
    timeout_d  = timeout_q;
    capture    = 1'b0;
    m_read     = 1'b0;
    m_address  = 1'b0;
    busy       = 1'b0;

    case (state_q)
      IDLE: begin
        if (start || (AUTO_START && !started_q)) state_d = RD_ID;
      end
      RD_ID, RD_TS: begin
        m_read    = 1'b1;
        busy      = 1'b1;
        m_address = (state_q == RD_TS);
        if (!m_waitrequest) begin
          if (LAT_EN) begin
            lat_d   = LAT_LOAD;
            state_d = (state_q == RD_ID) ? LAT_ID : LAT_TS;
          end else begin
            capture = 1'b1;
          end
        end else if (TO_EN && (stall_q == '0)) begin
          timeout_d = 1'b1;
          state_d   = DONE;
        end else begin
          stall_d = stall_q - TO_W'(1);
        end
      end
      LAT_ID, LAT_TS: begin
        busy = 1'b1;
        if (lat_q == 3'd0) capture = 1'b1;
        else               lat_d   = lat_q - 3'd1;
      end
      DONE: begin
        if (start) state_d = RD_ID;
      end
      default: state_d = IDLE;
    endcase

    if (capture) begin
      if ((state_q == RD_ID) || (state_q == LAT_ID)) begin
        id_value_d = m_readdata;
        id_got_d   = 1'b1;
        state_d    = RD_TS;
      end else begin
        ts_value_d = m_readdata;
        ts_got_d   = 1'b1;
        state_d    = DONE;
      end
    end

    // stall budget restarts at every read launch
    if (state_d != state_q) stall_d = TO_LOAD;

    if ((state_d == RD_ID) && (state_q != RD_ID)) begin
      done_d    = 1'b0;
      id_ok_d   = 1'b0;
      ts_ok_d   = 1'b0;
      timeout_d = 1'b0;
      id_got_d  = 1'b0;
      ts_got_d  = 1'b0;
    end

    if ((state_d == DONE) && (state_q != DONE)) begin
      done_d  = 1'b1;
      id_ok_d = id_got_d && (id_value_d == EXPECTED_ID);
      ts_ok_d = ts_got_d && (ts_value_d == EXPECTED_TIMESTAMP);
    end

`ifdef SYSID_BOOT_CHECKER_IRQ_EN
    irq_d = irq_q;
    if (irq_ack) irq_d = 1'b0;
    if ((state_d == DONE) && (state_q != DONE) && (!id_ok_d || !ts_ok_d || timeout_d)) irq_d = 1'b1;
`endif
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      started_q  <= 1'b0;
      stall_q    <= '0;
      lat_q      <= 3'd0;
      id_value_q <= 32'd0;
      ts_value_q <= 32'd0;
      id_got_q   <= 1'b0;
      ts_got_q   <= 1'b0;
      done_q     <= 1'b0;
      id_ok_q    <= 1'b0;
      ts_ok_q    <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      started_q  <= started_d;
      stall_q    <= stall_d;
      lat_q      <= lat_d;
      id_value_q <= id_value_d;
      ts_value_q <= ts_value_d;
      id_got_q   <= id_got_d;
      ts_got_q   <= ts_got_d;
      done_q     <= done_d;
      id_ok_q    <= id_ok_d;
      ts_ok_q    <= ts_ok_d;
      timeout_q  <= timeout_d;
    end
  end

`ifdef SYSID_BOOT_CHECKER_IRQ_EN
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) irq_q <= 1'b0;
    else          irq_q <= irq_d;
  end

  assign irq = irq_q;
`endif

  assign done        = done_q;
  assign id_value    = id_value_q;
  assign ts_value    = ts_value_q;
  assign id_ok       = id_ok_q;
  assign ts_ok       = ts_ok_q;
  assign timeout_err = timeout_q;

endmodule

// File: tb/tb_sysid_boot_checker.sv
// Bench for sysid_boot_checker: two instances (latency 0 / auto-start, latency 2 / timeout 8)
// driven by directed and random reads, checked against a cycle-count and value model.
module tb_sysid_boot_checker;

  localparam logic [31:0] EXP_ID = 32'h0000_0000;
  localparam logic [31:0] EXP_TS = 32'h5896_7A1C;

  logic        clock   = 1'b0;
  logic        reset_n = 1'b1;
  logic [1:0]  start_s = 2'b00;
  wire  [1:0]  m_addr, m_rd, busy, done, id_ok, ts_ok, to_err;
  wire  [31:0] idv [2];
  wire  [31:0] tsv [2];
  wire  [31:0] rdata0, rdata1;
  wire  [1:0]  wreq;

  logic [31:0] mem_id [2] = '{EXP_ID, EXP_ID};
  logic [31:0] mem_ts [2] = '{EXP_TS, EXP_TS};
  int          wn_id  [2] = '{0, 0};
  int          wn_ts  [2] = '{0, 0};

  int          scnt  [2] = '{0, 0};
  int          acc   [2] = '{0, 0};
  int          tacc  [2] = '{0, 0};
  int          stab  [2] = '{0, 0};
  logic [1:0]  prev_stall = 2'b00;
  logic [1:0]  prev_addr  = 2'b00;
  logic [1:0]  pv = 2'b00;
  logic [1:0]  pa = 2'b00;

  logic [31:0] exp_idv [2] = '{32'd0, 32'd0};
  logic [31:0] exp_tsv [2] = '{32'd0, 32'd0};
  logic        exp_irq [2] = '{1'b0, 1'b0};

  int n_cmp = 0;
  int n_err = 0;

`ifdef SYSID_BOOT_CHECKER_IRQ_EN
  wire  [1:0] irq;
  logic [1:0] irq_ack = 2'b00;
`endif

  always #5 clock = ~clock;

  // slave model: programmable stall per address; dut1 returns data two cycles after acceptance
  assign wreq[0] = m_rd[0] && (scnt[0] < (m_addr[0] ? wn_ts[0] : wn_id[0]));
  assign wreq[1] = m_rd[1] && (scnt[1] < (m_addr[1] ? wn_ts[1] : wn_id[1]));
  assign rdata0  = m_rd[0] ? (m_addr[0] ? mem_ts[0] : mem_id[0]) : 32'hDEAD_BEEF;
  assign rdata1  = pv[1]   ? (pa[1]     ? mem_ts[1] : mem_id[1]) : 32'hBAD0_0BAD;

  always @(posedge clock) begin
    for (int d = 0; d < 2; d++) begin
      scnt[d] <= (m_rd[d] && wreq[d]) ? scnt[d] + 1 : 0;
      if (m_rd[d] && !wreq[d]) acc[d] <= acc[d] + 1;
      if (m_rd[d] && !wreq[d] && m_addr[d]) tacc[d] <= tacc[d] + 1;
      if (prev_stall[d] && m_rd[d] && (m_addr[d] != prev_addr[d])) stab[d] <= stab[d] + 1;
    end
    prev_stall <= m_rd & wreq;
    prev_addr  <= m_addr;
    pv <= {pv[0], m_rd[1] && !wreq[1]};
    pa <= {pa[0], m_addr[1]};
  end

  sysid_boot_checker u_dut0 (
    .clock(clock), .reset_n(reset_n), .start(start_s[0]),
    .m_address(m_addr[0]), .m_read(m_rd[0]), .m_readdata(rdata0), .m_waitrequest(wreq[0]),
    .busy(busy[0]), .done(done[0]), .id_value(idv[0]), .ts_value(tsv[0]),
    .id_ok(id_ok[0]), .ts_ok(ts_ok[0]), .timeout_err(to_err[0])
`ifdef SYSID_BOOT_CHECKER_IRQ_EN
    , .irq(irq[0]), .irq_ack(irq_ack[0])
`endif
  );

  sysid_boot_checker #(.READ_LATENCY(2), .TIMEOUT_CYCLES(8), .AUTO_START(1'b0)) u_dut1 (
    .clock(clock), .reset_n(reset_n), .start(start_s[1]),
    .m_address(m_addr[1]), .m_read(m_rd[1]), .m_readdata(rdata1), .m_waitrequest(wreq[1]),
    .busy(busy[1]), .done(done[1]), .id_value(idv[1]), .ts_value(tsv[1]),
    .id_ok(id_ok[1]), .ts_ok(ts_ok[1]), .timeout_err(to_err[1])
`ifdef SYSID_BOOT_CHECKER_IRQ_EN
    , .irq(irq[1]), .irq_ack(irq_ack[1])
`endif
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic reset_out_zero();
    chk("rst_ctrl", {m_rd, m_addr, busy, done, id_ok, ts_ok, to_err}, 64'd0);
    chk("rst_values", 64'(|{idv[0], tsv[0], idv[1], tsv[1]}), 64'd0);
`ifdef SYSID_BOOT_CHECKER_IRQ_EN
    chk("rst_irq", 64'(irq), 64'd0);
`endif
  endtask

  // called right after reset_n rises at a negedge; dut0 must self-start with a matching image
  task automatic auto_check();
    int n = 0;
    int a0 = acc[0];
    mem_id[0] = EXP_ID; mem_ts[0] = EXP_TS; wn_id[0] = 0; wn_ts[0] = 0;
    while (n < 20) begin
      @(negedge clock); n++;
      if (done[0]) break;
    end
    exp_idv[0] = EXP_ID; exp_tsv[0] = EXP_TS;
    chk("auto_latency", 64'(n), 64'd3);
    chk("auto_flags", {61'd0, id_ok[0], ts_ok[0], to_err[0]}, 64'b110);
    chk("auto_reads", 64'(acc[0] - a0), 64'd2);
    chk("auto_values", {idv[0], tsv[0]}, {exp_idv[0], exp_tsv[0]});
    chk("dut1_no_autostart", {62'd0, busy[1], done[1]}, 64'd0);
  endtask

  // one check on DUT d; poke>0 pulses start again at that cycle of the run (must be ignored)
  task automatic run_check(input int d, input logic [31:0] w_id, input logic [31:0] w_ts,
                           input int wi, input int wt, input int poke);
    int lat = (d == 1) ? 2 : 0;
    int to  = (d == 1) ? 8 : 255;
    int n, exp_n, e_acc, a0, t0, s0;
    logic e_id_ok, e_ts_ok, e_to;
    mem_id[d] = w_id; mem_ts[d] = w_ts; wn_id[d] = wi; wn_ts[d] = wt;
    if (wi >= to) begin
      exp_n = 1 + to; e_to = 1'b1; e_id_ok = 1'b0; e_ts_ok = 1'b0; e_acc = 0;
    end else begin
      exp_idv[d] = w_id;
      e_id_ok = (w_id == EXP_ID);
      if (wt >= to) begin
        exp_n = 1 + (wi + 1 + lat) + to; e_to = 1'b1; e_ts_ok = 1'b0; e_acc = 1;
      end else begin
        exp_tsv[d] = w_ts;
        exp_n = 1 + (wi + 1 + lat) + (wt + 1 + lat);
        e_to = 1'b0; e_ts_ok = (w_ts == EXP_TS); e_acc = 2;
      end
    end
    a0 = acc[d]; t0 = tacc[d]; s0 = stab[d];
    @(negedge clock); start_s[d] = 1'b1;
    @(negedge clock); start_s[d] = 1'b0; n = 1;
    chk("busy_at_launch", 64'(busy[d]), 64'd1);
    chk("flags_cleared", {60'd0, done[d], id_ok[d], ts_ok[d], to_err[d]}, 64'd0);
    while (n < 400) begin
      if (done[d]) break;
      start_s[d] = (n == poke);
      @(negedge clock); n++;
    end
    start_s[d] = 1'b0;
    chk("done_latency", 64'(n), 64'(exp_n));
    chk("ok_flags", {61'd0, id_ok[d], ts_ok[d], to_err[d]}, {61'd0, e_id_ok, e_ts_ok, e_to});
    chk("id_value", 64'(idv[d]), 64'(exp_idv[d]));
    chk("ts_value", 64'(tsv[d]), 64'(exp_tsv[d]));
    chk("accepted_reads", 64'(acc[d] - a0), 64'(e_acc));
    chk("addr1_reads", 64'(tacc[d] - t0), 64'((e_acc == 2) ? 1 : 0));
    chk("stall_stable", 64'(stab[d] - s0), 64'd0);
    repeat (3) @(negedge clock);
    chk("no_requeue", {62'd0, busy[d], done[d]}, 64'b01);
`ifdef SYSID_BOOT_CHECKER_IRQ_EN
    exp_irq[d] = exp_irq[d] | !(e_id_ok && e_ts_ok && !e_to);
    chk("irq_set", 64'(irq[d]), 64'(exp_irq[d]));
    irq_ack[d] = 1'b1; @(negedge clock); irq_ack[d] = 1'b0;
    exp_irq[d] = 1'b0;
    chk("irq_ack", 64'(irq[d]), 64'd0);
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    #1 reset_n = 1'b0;
    #2 reset_out_zero();
    @(negedge clock); @(negedge clock);
    reset_n = 1'b1;
    auto_check();

    // stale timestamp on the latency-0 instance
    run_check(0, EXP_ID, EXP_TS + 32'd1, 0, 0, 0);
    // matching re-run with a start pulse while busy
    run_check(0, EXP_ID, EXP_TS, 0, 0, 2);
    // 5-cycle stalls on both reads with latency 2
    run_check(1, EXP_ID, EXP_TS, 5, 5, 3);
    // ID read stuck: timeout, no address-1 read, values retained
    run_check(1, EXP_ID, EXP_TS, 100, 0, 0);
    // wrong ID, then timestamp read times out
    run_check(1, 32'h1234_5678, EXP_TS, 2, 50, 0);

    for (int i = 0; i < 12; i++) begin
      int d = i % 2;
      logic [31:0] wi_word = ($urandom_range(0, 1) == 1) ? EXP_ID : $urandom();
      logic [31:0] wt_word = ($urandom_range(0, 1) == 1) ? EXP_TS : $urandom();
      run_check(d, wi_word, wt_word, $urandom_range(0, (d == 1) ? 10 : 6),
                $urandom_range(0, (d == 1) ? 10 : 6), $urandom_range(1, 4));
    end

    // reset asserted while dut1 is mid timestamp read
    mem_id[1] = EXP_ID; mem_ts[1] = EXP_TS; wn_id[1] = 1; wn_ts[1] = 20;
    @(negedge clock); start_s[1] = 1'b1;
    @(negedge clock); start_s[1] = 1'b0;
    n = 0;
    while (!(m_rd[1] && m_addr[1]) && n < 40) begin
      @(negedge clock); n++;
    end
    chk("reach_rd_ts", 64'(m_rd[1] && m_addr[1]), 64'd1);
    #2 reset_n = 1'b0;
    #1 reset_out_zero();
    @(negedge clock);
    reset_n = 1'b1;
    exp_idv = '{32'd0, 32'd0}; exp_tsv = '{32'd0, 32'd0}; exp_irq = '{1'b0, 1'b0};
    auto_check();
    run_check(1, EXP_ID, EXP_TS, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/sysid_boot_checker.md
Name: sysid_boot_checker

Overview:
- Avalon-MM read master that sequences two reads of the system-ID slave: address 0 returns the ID and address 1 returns the build timestamp.
- Compares both words against compiled-in expected values and publishes sticky pass/fail status.
- Sits between the sysid slave's control port and board status logic (LEDs, boot gating), so a mismatched FPGA image is flagged before the Nios II software runs.
- Re-check is available on demand through a start pulse.

Parameters:
- EXPECTED_ID, 32'h00000000, ID value that must be read from address 0.
- EXPECTED_TIMESTAMP, 32'h58967A1C, timestamp value that must be read from address 1.
- READ_LATENCY, 0, cycles from read acceptance to valid m_readdata. Range 0..7.
- TIMEOUT_CYCLES, 255, maximum number of waitrequest-stalled cycles per read. 0 disables the timeout.
- AUTO_START, 1, when 1, a check runs automatically after reset release.

Ports:
- clock  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- start  in  1  single-cycle request to run a check
- m_address  out  1  sysid word select: 0 = ID, 1 = timestamp
- m_read  out  1  Avalon read strobe
- m_readdata  in  32  read data from the sysid slave
- m_waitrequest  in  1  slave stall; tie to 0 for the sysid slave
- busy  out  1  check in progress
- done  out  1  sticky; check finished
- id_value  out  32  captured ID word
- ts_value  out  32  captured timestamp word
- id_ok  out  1  id_value == EXPECTED_ID; valid only while done=1
- ts_ok  out  1  ts_value == EXPECTED_TIMESTAMP; valid only while done=1
- timeout_err  out  1  a read stalled beyond TIMEOUT_CYCLES

Behaviour:
- Clock and reset: one clock domain. reset_n is asynchronous and active-low. Every output and register clears to 0 and the FSM goes to IDLE.
- FSM states: IDLE, RD_ID, LAT_ID, RD_TS, LAT_TS, DONE.
- IDLE: moves to RD_ID when start=1. If AUTO_START=1, also moves to RD_ID in the first clock after reset deassertion.
- Entering RD_ID clears done, id_ok, ts_ok and timeout_err. id_value and ts_value keep their old values until they are overwritten.
- RD_ID: drives m_read=1 and m_address=0. Both stay stable while m_waitrequest=1. A read is accepted on the first cycle with m_waitrequest=0.
- Latency 0 handling: if READ_LATENCY=0, m_readdata is captured into id_value in the acceptance cycle and the FSM goes to RD_TS.
- Latency >0 handling: the FSM goes to LAT_ID with m_read=0, counts READ_LATENCY cycles, captures on the last count, then goes to RD_TS.
- m_read drops in the cycle after acceptance. There are never back-to-back reads without a transition through the next state.
- RD_TS and LAT_TS: identical to RD_ID and LAT_ID, but with m_address=1 and capture into ts_value. After capture the FSM goes to DONE.
- Timeout: a stall counter resets at each read launch and increments on each cycle where m_waitrequest=1.
  - When it reaches TIMEOUT_CYCLES (and TIMEOUT_CYCLES is nonzero), timeout_err is set, m_read drops the next cycle, and the FSM goes straight to DONE.
  - Words not captured in that run keep their prior values, and the corresponding ok flag stays 0.
- DONE entry: done=1. id_ok and ts_ok are registered on DONE entry, each forced to 0 if its own read did not complete.
- DONE exit: start=1 moves the FSM to RD_ID.
- busy=1 in RD_ID, LAT_ID, RD_TS and LAT_TS; busy=0 otherwise.
- start while busy=1 is ignored and does not queue.
- Throughput: with zero waits and READ_LATENCY=0, done asserts 3 cycles after the start cycle.
- Reset mid-read: m_read drops immediately (asynchronous). A check does not resume unless AUTO_START=1.

Optional Feature:
- Macro: SYSID_BOOT_CHECKER_IRQ_EN.
- When defined, the block adds ports irq (out, 1) and irq_ack (in, 1).
  - irq sets in the DONE-entry cycle if id_ok=0, ts_ok=0 or timeout_err=1.
  - irq stays set until irq_ack=1. If an ack and a new set event land in the same cycle, the set wins.
  - A reset clears irq.
- When the macro is undefined, neither port exists and there is no irq logic.

Test Plan:
- Matching image: slave returns 0x00000000 at address 0 and 0x58967A1C at address 1, waitrequest=0, latency 0, AUTO_START=1. Required: done=1 on the third cycle after reset release, id_ok=1, ts_ok=1, timeout_err=0, exactly two m_read pulses.
- Stale image: timestamp returns 0x58967A1D. Required: id_ok=1, ts_ok=0, ts_value=0x58967A1D; with the IRQ macro, irq=1 until irq_ack.
- Stalls and latency: waitrequest held high for 5 cycles on each read, READ_LATENCY=2. Required: address and read stable during the stall, captured values correct, done asserts 1+6+2+6+2 cycles after start.
- Timeout: TIMEOUT_CYCLES=8, waitrequest stuck at 1 on the ID read. Required: timeout_err=1, done=1, id_ok=0, ts_ok=0, no address-1 read issued, m_read low within 9 cycles.
- Control corner cases: a start pulse while busy is ignored (only one check runs); a start pulse in DONE re-runs the check and clears the ok flags during the run; reset_n pulsed low during RD_TS gives all outputs 0 asynchronously and a clean re-check afterwards.
